wb_write_arbiter: RTL and testbench

//  Writer side of the register file's single write port. Merges two result sources into one registered

---
 rtl/wb_write_arbiter_if.sv | 39 +++
 rtl/wb_write_arbiter.sv | 127 ++++++++++++
 tb/tb_wb_write_arbiter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_write_arbiter_if.sv
// Register-file write-port bundle: pipeline writeback, MDU result handshake,
// registered write outputs and FIFO status.
interface wb_write_arbiter_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned NR = 1 << AW;

    logic          in_wb_wena;
    logic [AW-1:0] in_wb_addr;
    logic [DW-1:0] in_wb_data;
    logic          in_mdu_valid;
    logic [AW-1:0] in_mdu_addr;
    logic [DW-1:0] in_mdu_data;
    logic          out_mdu_ready;
    logic          out_rd_wena;
    logic [AW-1:0] out_rd_addr;
    logic [DW-1:0] out_rd_data;
    logic [NR-1:0] out_busy_mask;
    logic [CW-1:0] out_fifo_count;

    modport slave (
        input  in_wb_wena, in_wb_addr, in_wb_data,
        input  in_mdu_valid, in_mdu_addr, in_mdu_data,
        output out_mdu_ready,
        output out_rd_wena, out_rd_addr, out_rd_data,
        output out_busy_mask, out_fifo_count
    );

    modport master (
        output in_wb_wena, in_wb_addr, in_wb_data,
        output in_mdu_valid, in_mdu_addr, in_mdu_data,
        input  out_mdu_ready,
        input  out_rd_wena, out_rd_addr, out_rd_data,
        input  out_busy_mask, out_fifo_count
    );
endinterface

// File: rtl/wb_write_arbiter.sv
// Single register-file write port shared by in-order writeback (priority) and
// a FIFO-buffered multiply/divide unit, with WAW kill and a pending-write busy mask.
module wb_write_arbiter #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
) (
    input  logic                    in_clk,
    input  logic                    in_rst_n,
    wb_write_arbiter_if.slave       bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned NR = 1 << AW;

    typedef struct packed {
        logic          live;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } entry_t;

    entry_t        fifo_q [DEPTH];
    entry_t        fifo_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          rd_wena_q, rd_wena_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [DW-1:0] rd_data_q, rd_data_d;

    logic          wb_fire_c;
    logic          mdu_ready_c;
    logic          push_c;
    logic          pop_c;
    entry_t        head_entry_c;
    logic [NR-1:0] busy_mask_c;

    // Handshake and source selection; writes to r0 never count as a pipeline write.
    always_comb begin
        wb_fire_c    = bus.in_wb_wena && (bus.in_wb_addr != '0);
        mdu_ready_c  = (count_q < CW'(DEPTH));
        push_c       = bus.in_mdu_valid && mdu_ready_c && (bus.in_mdu_addr != '0);
        pop_c        = !wb_fire_c && (count_q != '0);
        head_entry_c = fifo_q[head_q];
    end

    // FIFO next state: kill first, then pop clears its slot, then push overwrites the
    // tail so a same-cycle push to the written register survives as the younger write.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            fifo_d[i] = fifo_q[i];
            if (wb_fire_c && (fifo_q[i].addr == bus.in_wb_addr)) begin
                fifo_d[i].live = 1'b0;
            end
        end
        if (pop_c) begin
            fifo_d[head_q].live = 1'b0;
        end
        if (push_c) begin
            fifo_d[tail_q].live = 1'b1;
            fifo_d[tail_q].addr = bus.in_mdu_addr;
            fifo_d[tail_q].data = bus.in_mdu_data;
        end
        head_d  = pop_c  ? head_q + PW'(1) : head_q;
        tail_d  = push_c ? tail_q + PW'(1) : tail_q;
        count_d = count_q + CW'(push_c) - CW'(pop_c);
    end

    // Write-port mux; a killed head is popped silently.
    always_comb begin
        rd_wena_d = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        if (wb_fire_c) begin
            rd_wena_d = 1'b1;
            rd_addr_d = bus.in_wb_addr;
            rd_data_d = bus.in_wb_data;
        end else if (pop_c && head_entry_c.live) begin
            rd_wena_d = 1'b1;
            rd_addr_d = head_entry_c.addr;
            rd_data_d = head_entry_c.data;
        end
    end

    // Busy mask from live entries only; popped and killed slots are already dead.
    always_comb begin
        busy_mask_c = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (fifo_q[i].live) begin
                busy_mask_c[fifo_q[i].addr] = 1'b1;
            end
        end
        busy_mask_c[0] = 1'b0;
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_q[i] <= '0;
            end
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            rd_wena_q <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_q[i] <= fifo_d[i];
            end
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            rd_wena_q <= rd_wena_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign bus.out_mdu_ready  = mdu_ready_c;
    assign bus.out_rd_wena    = rd_wena_q;
    assign bus.out_rd_addr    = rd_addr_q;
    assign bus.out_rd_data    = rd_data_q;
    assign bus.out_busy_mask  = busy_mask_c;
    assign bus.out_fifo_count = count_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Scoreboard bench for wb_write_arbiter: directed stimulus queues expected
// register-file writes; a negedge monitor checks every write the DUT issues.
module tb_wb_write_arbiter;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 5;
    localparam int unsigned DW    = 32;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_write_arbiter_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus();

    wb_write_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .in_clk   (clk),
        .in_rst_n (rst_n),
        .bus      (bus)
    );

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic exp_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_wb_wena   = 1'b0;
        bus.in_wb_addr   = '0;
        bus.in_wb_data   = '0;
        bus.in_mdu_valid = 1'b0;
        bus.in_mdu_addr  = '0;
        bus.in_mdu_data  = '0;
    endtask

    task automatic wb(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.in_wb_wena = 1'b1;
        bus.in_wb_addr = a;
        bus.in_wb_data = d;
    endtask

    task automatic mdu(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.in_mdu_valid = 1'b1;
        bus.in_mdu_addr  = a;
        bus.in_mdu_data  = d;
    endtask

    // Monitor: every issued write must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && bus.out_rd_wena) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got r%0d=0x%0h expected no write",
                         bus.out_rd_addr, bus.out_rd_data);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                if (bus.out_rd_addr !== w.addr || bus.out_rd_data !== w.data) begin
                    n_bad++;
                    $display("FAIL rf_write: got r%0d=0x%0h expected r%0d=0x%0h",
                             bus.out_rd_addr, bus.out_rd_data, w.addr, w.data);
                end
            end
        end
    end

    initial begin
        idle();
        #1;
        chk("reset_wena",  64'(bus.out_rd_wena),    64'h0);
        chk("reset_addr",  64'(bus.out_rd_addr),    64'h0);
        chk("reset_data",  64'(bus.out_rd_data),    64'h0);
        chk("reset_count", 64'(bus.out_fifo_count), 64'h0);
        chk("reset_mask",  64'(bus.out_busy_mask),  64'h0);
        cyc();
        cyc();
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("ready_after_reset", 64'(bus.out_mdu_ready), 64'h1);

        // Pipeline write, then dropped r0 write
        wb(5, 32'h11); exp_wr(5, 32'h11);
        cyc();
        chk("wb_r5_wena", 64'(bus.out_rd_wena), 64'h1);
        wb(0, 32'h22);
        cyc();
        chk("wb_r0_wena", 64'(bus.out_rd_wena), 64'h0);
        chk("wb_r0_addr_hold", 64'(bus.out_rd_addr), 64'h5);
        idle();

        // Two MDU results on an idle pipeline
        mdu(6, 32'hA); exp_wr(6, 32'hA);
        cyc();
        chk("mdu_mask_r6", 64'(bus.out_busy_mask), 64'h40);
        chk("mdu_count_1", 64'(bus.out_fifo_count), 64'h1);
        idle();
        mdu(7, 32'hB); exp_wr(7, 32'hB);
        cyc();
        chk("mdu_mask_r7", 64'(bus.out_busy_mask), 64'h80);
        idle();
        cyc();
        chk("mdu_mask_clear", 64'(bus.out_busy_mask), 64'h0);
        chk("mdu_count_0", 64'(bus.out_fifo_count), 64'h0);

        // Fill while pipeline keeps the port busy
        for (int k = 0; k < 4; k++) begin
            wb(AW'(10 + k), DW'(32'h100 + k)); exp_wr(AW'(10 + k), DW'(32'h100 + k));
            mdu(AW'(20 + k), DW'(32'h200 + k));
            cyc();
        end
        chk("full_count", 64'(bus.out_fifo_count), 64'h4);
        chk("full_ready", 64'(bus.out_mdu_ready), 64'h0);
        wb(10, 32'h104); exp_wr(10, 32'h104);
        mdu(24, 32'h999);
        cyc();
        chk("full_no_push_count", 64'(bus.out_fifo_count), 64'h4);
        chk("full_mask", 64'(bus.out_busy_mask), 64'h00F0_0000);
        idle();
        for (int k = 0; k < 4; k++) exp_wr(AW'(20 + k), DW'(32'h200 + k));
        cyc();
        chk("drain_ready", 64'(bus.out_mdu_ready), 64'h1);
        chk("drain_count", 64'(bus.out_fifo_count), 64'h3);
        cyc(); cyc(); cyc();
        chk("drained_count", 64'(bus.out_fifo_count), 64'h0);
        chk("drained_mask", 64'(bus.out_busy_mask), 64'h0);

        // WAW kill
        wb(1, 32'h77); exp_wr(1, 32'h77);
        mdu(9, 32'h1);
        cyc();
        chk("kill_mask_before", 64'(bus.out_busy_mask), 64'h200);
        idle();
        wb(9, 32'h2); exp_wr(9, 32'h2);
        cyc();
        chk("kill_mask_after", 64'(bus.out_busy_mask), 64'h0);
        chk("kill_count", 64'(bus.out_fifo_count), 64'h1);
        idle();
        cyc();
        chk("killed_pop_wena", 64'(bus.out_rd_wena), 64'h0);
        chk("killed_pop_count", 64'(bus.out_fifo_count), 64'h0);

        // Same-cycle push and pipeline write to r3
        wb(3, 32'h4); exp_wr(3, 32'h4);
        mdu(3, 32'h5); exp_wr(3, 32'h5);
        cyc();
        chk("same_mask_r3", 64'(bus.out_busy_mask), 64'h8);
        idle();
        cyc();
        chk("same_mask_clear", 64'(bus.out_busy_mask), 64'h0);

        // Reset mid-stream with three entries queued
        for (int k = 0; k < 3; k++) begin
            wb(1, DW'(32'h50 + k)); exp_wr(1, DW'(32'h50 + k));
            mdu(AW'(14 + k), DW'(32'h300 + k));
            cyc();
        end
        chk("prerst_count", 64'(bus.out_fifo_count), 64'h3);
        chk("prerst_mask", 64'(bus.out_busy_mask), 64'h0001_C000);
        idle();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_count", 64'(bus.out_fifo_count), 64'h0);
        chk("rst_mask",  64'(bus.out_busy_mask),  64'h0);
        chk("rst_wena",  64'(bus.out_rd_wena),    64'h0);
        cyc();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) cyc();
        chk("postrst_count", 64'(bus.out_fifo_count), 64'h0);
        chk("postrst_wena",  64'(bus.out_rd_wena),    64'h0);
        chk("scoreboard_drain", 64'(exp_q.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
